// File: rtl/tcdm_bank_responder_pkg.sv
// Shared constants, response payload and LFSR helper for the TCDM bank responder.
package tcdm_resp_package;

  localparam int unsigned WORD_W = 32;

  // Right-shifting Fibonacci LFSR for x^16+x^14+x^13+x^11+1.
  // Taps at bits 0,2,3,5; the feedback bit enters at the MSB.
  localparam int unsigned          LFSR_W    = 16;
  localparam logic [LFSR_W-1:0]    LFSR_TAPS = 16'h002D;
  localparam logic [LFSR_W-1:0]    LFSR_SEED = 16'hACE1;

  typedef struct packed {
    logic              r_valid;
    logic [WORD_W-1:0] r_data;
  } tcdm_resp_t;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {^(s & LFSR_TAPS), s[LFSR_W-1:1]};
  endfunction

endpackage

// File: rtl/hwpe_stream_intf_tcdm.sv
// TCDM request/response channel between an HWPE streamer and a memory bank.
interface hwpe_stream_intf_tcdm;

  logic        req;
  logic        gnt;
  logic [31:0] add;
  logic        wen;
  logic [3:0]  be;
  logic [31:0] data;
  logic [31:0] r_data;
  logic        r_valid;

  modport master (
    output req, add, wen, be, data,
    input  gnt, r_data, r_valid
  );

  modport slave (
    input  req, add, wen, be, data,
    output gnt, r_data, r_valid
  );

endinterface

// File: rtl/tcdm_bank_responder_arbiter.sv
// Round-robin arbiter: one grant per cycle, search starts at the pointer.
module tcdm_rr_arbiter #(
  parameter  int unsigned NB_PORTS = 3,
  localparam int unsigned IDX_W    = (NB_PORTS > 1) ? $clog2(NB_PORTS) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clear_i,
  input  logic                stall_i,
  input  logic [NB_PORTS-1:0] req_i,
  output logic [NB_PORTS-1:0] gnt_oh_c,
  output logic [IDX_W-1:0]    gnt_idx_c,
  output logic                gnt_valid_c
);

  logic [IDX_W-1:0] rr_q;
  logic [IDX_W-1:0] rr_d;

  // First requesting port at or after the pointer, modulo NB_PORTS
  always_comb begin
    int unsigned cand;
    cand        = 0;
    gnt_oh_c    = '0;
    gnt_idx_c   = '0;
    gnt_valid_c = 1'b0;
    for (int unsigned i = 0; i < NB_PORTS; i++) begin
      cand = 32'(rr_q) + i;
      if (cand >= NB_PORTS) cand = cand - NB_PORTS;
      if (!gnt_valid_c && req_i[IDX_W'(cand)]) begin
        gnt_valid_c = 1'b1;
        gnt_idx_c   = IDX_W'(cand);
      end
    end
    if (stall_i) gnt_valid_c = 1'b0;
    if (gnt_valid_c) gnt_oh_c[gnt_idx_c] = 1'b1;
  end

  // Pointer moves past the winner; clear returns it to port 0
  always_comb begin
    rr_d = rr_q;
    if (clear_i) begin
      rr_d = '0;
    end else if (gnt_valid_c) begin
      rr_d = (32'(gnt_idx_c) == NB_PORTS - 1) ? '0 : gnt_idx_c + IDX_W'(1);
    end
  end

  // Pointer register
  always_ff @(posedge clk_i) begin
    if (rst_i) rr_q <= '0;
    else       rr_q <= rr_d;
  end

endmodule

// File: rtl/tcdm_bank_responder.sv
// Single-bank TCDM memory model serving NB_PORTS streamer ports, one access
// per cycle, round-robin arbitrated, one-cycle read latency.
// Optional random back-pressure: define TCDM_RESP_STALL_EN.
module tcdm_bank_responder
  import tcdm_resp_package::*;
#(
  parameter int unsigned        NB_PORTS   = 3,
  parameter int unsigned        DATA_WIDTH = 32,
  parameter int unsigned        MEM_WORDS  = 1024,
  parameter logic [31:0]        BASE_ADDR  = 32'h0,
  parameter logic [LFSR_W-1:0]  STALL_SEED = LFSR_SEED
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  hwpe_stream_intf_tcdm.slave  tcdm [NB_PORTS],
  output logic [31:0]          rd_cnt_o,
  output logic [31:0]          wr_cnt_o,
  output logic                 err_o
);

  localparam int unsigned BE_W   = DATA_WIDTH / 8;
  localparam int unsigned MEM_AW = $clog2(MEM_WORDS);
  localparam int unsigned IDX_W  = (NB_PORTS > 1) ? $clog2(NB_PORTS) : 1;

  logic [NB_PORTS-1:0]   req;
  logic [31:0]           add_a  [NB_PORTS];
  logic                  wen_a  [NB_PORTS];
  logic [BE_W-1:0]       be_a   [NB_PORTS];
  logic [DATA_WIDTH-1:0] data_a [NB_PORTS];
  tcdm_resp_t            resp_q [NB_PORTS];

  logic [NB_PORTS-1:0]   gnt_oh;
  logic [IDX_W-1:0]      gnt_idx;
  logic                  gnt_valid;
  logic                  stall;

  logic [31:0]           sel_add;
  logic [31:0]           sel_off;
  logic                  sel_wen;
  logic [BE_W-1:0]       sel_be;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [MEM_AW-1:0]     sel_widx;
  logic                  sel_misaligned;
  logic                  unused_off;

  logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];

  // Flatten the interface array into plain vectors
  for (genvar g = 0; g < NB_PORTS; g++) begin : g_port
    assign req[g]          = tcdm[g].req;
    assign add_a[g]        = tcdm[g].add;
    assign wen_a[g]        = tcdm[g].wen;
    assign be_a[g]         = tcdm[g].be;
    assign data_a[g]       = tcdm[g].data;
    assign tcdm[g].gnt     = gnt_oh[g];
    assign tcdm[g].r_valid = resp_q[g].r_valid;
    assign tcdm[g].r_data  = resp_q[g].r_data;
  end

`ifdef TCDM_RESP_STALL_EN
  logic [LFSR_W-1:0] lfsr_q;

  // Free-running back-pressure LFSR; only reset reseeds it
  always_ff @(posedge clk_i) begin
    if (rst_i) lfsr_q <= STALL_SEED;
    else       lfsr_q <= lfsr_next(lfsr_q);
  end

  assign stall = (lfsr_q[1:0] == 2'b00);
`else
  logic unused_seed;
  assign unused_seed = ^STALL_SEED;
  assign stall       = 1'b0;
`endif

  // No grant is issued while reset is held
  tcdm_rr_arbiter #(
    .NB_PORTS (NB_PORTS)
  ) i_arb (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (clear_i),
    .stall_i     (stall | rst_i),
    .req_i       (req),
    .gnt_oh_c    (gnt_oh),
    .gnt_idx_c   (gnt_idx),
    .gnt_valid_c (gnt_valid)
  );

  // Winner's request fields and its word index within the bank
  always_comb begin
    sel_add        = add_a[gnt_idx];
    sel_wen        = wen_a[gnt_idx];
    sel_be         = be_a[gnt_idx];
    sel_data       = data_a[gnt_idx];
    sel_off        = sel_add - BASE_ADDR;
    sel_widx       = sel_off[MEM_AW+1:2];
    sel_misaligned = |sel_add[1:0];
  end

  // Out-of-window bits are dropped so addresses wrap onto the bank
  assign unused_off = ^{sel_off[31:MEM_AW+2], sel_off[1:0]};

  // Byte-masked write port; contents survive reset
  always_ff @(posedge clk_i) begin
    if (gnt_valid && !sel_wen) begin
      for (int unsigned b = 0; b < BE_W; b++) begin
        if (sel_be[b]) mem_q[sel_widx][8*b +: 8] <= sel_data[8*b +: 8];
      end
    end
  end

  // Response goes to the granted port only; writes answer with zero data
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned p = 0; p < NB_PORTS; p++) resp_q[p] <= '0;
    end else begin
      for (int unsigned p = 0; p < NB_PORTS; p++) begin
        resp_q[p].r_valid <= gnt_oh[p];
        resp_q[p].r_data  <= (gnt_oh[p] && sel_wen) ? mem_q[sel_widx] : '0;
      end
    end
  end

  // Access counters and sticky misalignment flag; clear wins over a grant
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      rd_cnt_o <= '0;
      wr_cnt_o <= '0;
      err_o    <= 1'b0;
    end else if (gnt_valid) begin
      if (sel_wen) rd_cnt_o <= rd_cnt_o + 32'd1;
      else         wr_cnt_o <= wr_cnt_o + 32'd1;
      if (sel_misaligned) err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tcdm_bank_responder.sv
// Bench for tcdm_bank_responder: reference model checked every cycle plus
// directed transactions with literal expectations.
module tb_tcdm_bank_responder;

  localparam int          NP   = 3;
  localparam int          MW   = 1024;
  localparam logic [31:0] BASE = 32'h0;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i;
  logic        clear_i;
  logic        req_v  [NP];
  logic [31:0] add_v  [NP];
  logic        wen_v  [NP];
  logic [3:0]  be_v   [NP];
  logic [31:0] data_v [NP];
  logic        gnt_v    [NP];
  logic        rvalid_v [NP];
  logic [31:0] rdata_v  [NP];
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;
  logic        err;

  int errors = 0;
  int checks = 0;

  hwpe_stream_intf_tcdm tcdm [NP] ();

  for (genvar g = 0; g < NP; g++) begin : g_if
    assign tcdm[g].req  = req_v[g];
    assign tcdm[g].add  = add_v[g];
    assign tcdm[g].wen  = wen_v[g];
    assign tcdm[g].be   = be_v[g];
    assign tcdm[g].data = data_v[g];
    assign gnt_v[g]     = tcdm[g].gnt;
    assign rvalid_v[g]  = tcdm[g].r_valid;
    assign rdata_v[g]   = tcdm[g].r_data;
  end

  tcdm_bank_responder #(
    .NB_PORTS   (NP),
    .DATA_WIDTH (32),
    .MEM_WORDS  (MW),
    .BASE_ADDR  (BASE),
    .STALL_SEED (SEED)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .clear_i  (clear_i),
    .tcdm     (tcdm),
    .rd_cnt_o (rd_cnt),
    .wr_cnt_o (wr_cnt),
    .err_o    (err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_mem   [MW];
  bit          m_known [MW];
  int          m_rr     = 0;
  int          m_grants = 0;
  logic [15:0] m_lfsr   = SEED;
  bit          e_rv  [NP];
  logic [31:0] e_rd  [NP];
  bit          e_kn  [NP];
  logic [31:0] e_rdcnt = 32'd0;
  logic [31:0] e_wrcnt = 32'd0;
  bit          e_err   = 1'b0;

  initial begin : compare
    int  gp;
    int  p;
    int  widx;
    bit  stalled;
    for (int i = 0; i < NP; i++) begin
      e_rv[i] = 1'b0; e_rd[i] = 32'd0; e_kn[i] = 1'b1;
    end
    forever begin
      @(negedge clk);
      stalled = 1'b0;
`ifdef TCDM_RESP_STALL_EN
      stalled = (m_lfsr[1:0] == 2'b00);
`endif
      gp = -1;
      if (!rst_i && !stalled) begin
        for (int k = 0; k < NP; k++) begin
          p = (m_rr + k) % NP;
          if (gp < 0 && req_v[p] === 1'b1) gp = p;
        end
      end
      for (int i = 0; i < NP; i++) begin
        check($sformatf("gnt[%0d]", i), 32'(gnt_v[i]), 32'(gp == i));
        check($sformatf("r_valid[%0d]", i), 32'(rvalid_v[i]), 32'(e_rv[i]));
        if (e_kn[i]) check($sformatf("r_data[%0d]", i), rdata_v[i], e_rd[i]);
      end
      check("rd_cnt", rd_cnt, e_rdcnt);
      check("wr_cnt", wr_cnt, e_wrcnt);
      check("err", 32'(err), 32'(e_err));

      // what the coming edge must produce
      if (rst_i) begin
        for (int i = 0; i < NP; i++) begin
          e_rv[i] = 1'b0; e_rd[i] = 32'd0; e_kn[i] = 1'b1;
        end
        e_rdcnt = 32'd0; e_wrcnt = 32'd0; e_err = 1'b0; m_rr = 0; m_lfsr = SEED;
      end else begin
`ifdef TCDM_RESP_STALL_EN
        m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
`endif
        for (int i = 0; i < NP; i++) begin
          e_rv[i] = 1'b0; e_rd[i] = 32'd0; e_kn[i] = 1'b1;
        end
        if (gp >= 0) begin
          m_grants++;
          widx = int'(((add_v[gp] - BASE) >> 2) & 32'(MW - 1));
          e_rv[gp] = 1'b1;
          if (wen_v[gp]) begin
            e_rd[gp] = m_mem[widx];
            e_kn[gp] = m_known[widx];
            e_rdcnt  = e_rdcnt + 32'd1;
          end else begin
            for (int b = 0; b < 4; b++)
              if (be_v[gp][b]) m_mem[widx][8*b +: 8] = data_v[gp][8*b +: 8];
            m_known[widx] = m_known[widx] || (be_v[gp] == 4'hF);
            e_wrcnt = e_wrcnt + 32'd1;
          end
          if (add_v[gp][1:0] != 2'b00) e_err = 1'b1;
          m_rr = (gp + 1) % NP;
        end
        if (clear_i) begin
          e_rdcnt = 32'd0; e_wrcnt = 32'd0; e_err = 1'b0; m_rr = 0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Issue one access on port p, hold until granted, return the response data
  task automatic access(input int p, input logic w, input logic [31:0] a,
                        input logic [3:0] b, input logic [31:0] d,
                        output logic [31:0] rd);
    bit got = 1'b0;
    req_v[p] = 1'b1; wen_v[p] = w; add_v[p] = a; be_v[p] = b; data_v[p] = d;
    for (int n = 0; n < 64 && !got; n++) begin
      #1;
      got = gnt_v[p];
      tick();
    end
    req_v[p] = 1'b0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL grant_timeout: port %0d got no gnt within 64 cycles", p);
    end
    rd = rdata_v[p];
  endtask

  task automatic clear_pulse();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
  endtask

  initial begin : stim
    logic [31:0] r;
    int          order [6];
    int          exp_order [6];
    int          g0;
    exp_order = '{0, 1, 2, 0, 1, 2};
    rst_i = 1'b1; clear_i = 1'b0;
    for (int i = 0; i < NP; i++) begin
      req_v[i] = 1'b0; add_v[i] = 32'd0; wen_v[i] = 1'b1; be_v[i] = 4'h0; data_v[i] = 32'd0;
    end
    repeat (3) tick();
    check("reset rd_cnt", rd_cnt, 32'd0);
    check("reset wr_cnt", wr_cnt, 32'd0);
    check("reset err", 32'(err), 32'd0);
    check("reset r_valid0", 32'(rvalid_v[0]), 32'd0);
    rst_i = 1'b0;
    tick();

    // write then read back through another port
    access(0, 1'b0, 32'h10, 4'hF, 32'hDEADBEEF, r);
    access(1, 1'b1, 32'h10, 4'hF, 32'h0, r);
    check("wr_rd data", r, 32'hDEADBEEF);
    check("wr_rd r_valid1", 32'(rvalid_v[1]), 32'd1);
    check("wr_rd rd_cnt", rd_cnt, 32'd1);
    check("wr_rd wr_cnt", wr_cnt, 32'd1);

    // byte-masked merge
    access(2, 1'b0, 32'h20, 4'hF, 32'h11223344, r);
    check("write r_data zero", r, 32'd0);
    access(2, 1'b0, 32'h20, 4'b0101, 32'hAABBCCDD, r);
    access(0, 1'b1, 32'h20, 4'h0, 32'h0, r);
    check("be merge", r, 32'h11BB33DD);

    // all ports contend for six cycles
    clear_pulse();
    check("clear rd_cnt", rd_cnt, 32'd0);
    for (int i = 0; i < NP; i++) begin
      req_v[i] = 1'b1; wen_v[i] = 1'b1; add_v[i] = 32'h10; be_v[i] = 4'hF;
    end
    for (int c = 0; c < 6; c++) begin
      #1;
      order[c] = -1;
      for (int i = 0; i < NP; i++) if (gnt_v[i]) order[c] = i;
      tick();
    end
    for (int i = 0; i < NP; i++) req_v[i] = 1'b0;
`ifndef TCDM_RESP_STALL_EN
    for (int c = 0; c < 6; c++) check($sformatf("rr order[%0d]", c), 32'(order[c]), 32'(exp_order[c]));
    check("rr last r_valid2", 32'(rvalid_v[2]), 32'd1);
    check("rr last r_data2", rdata_v[2], 32'hDEADBEEF);
    check("rr rd_cnt", rd_cnt, 32'd6);
`endif
    tick();

    // wrapped, misaligned read of word 0
    access(0, 1'b0, 32'h0, 4'hF, 32'hCAFEF00D, r);
    access(1, 1'b1, BASE + 32'(4 * MW) + 32'd1, 4'h0, 32'h0, r);
    check("wrap data", r, 32'hCAFEF00D);
    check("misaligned err", 32'(err), 32'd1);
    repeat (2) tick();
    check("err sticky", 32'(err), 32'd1);
    clear_pulse();
    check("clear err", 32'(err), 32'd0);
    check("clear rd_cnt2", rd_cnt, 32'd0);
    check("clear wr_cnt2", wr_cnt, 32'd0);

    // reset right after a read grant
    access(2, 1'b1, 32'h10, 4'hF, 32'h0, r);
    rst_i = 1'b1;
    tick();
    check("rst r_valid2", 32'(rvalid_v[2]), 32'd0);
    check("rst r_data2", rdata_v[2], 32'd0);
    check("rst rd_cnt", rd_cnt, 32'd0);
    rst_i = 1'b0;
    tick();
    check("post rst r_valid2", 32'(rvalid_v[2]), 32'd0);

`ifdef TCDM_RESP_STALL_EN
    // sustained reads under back-pressure
    clear_pulse();
    g0 = m_grants;
    req_v[0] = 1'b1; wen_v[0] = 1'b1; add_v[0] = 32'h20; be_v[0] = 4'hF;
    repeat (1000) tick();
    req_v[0] = 1'b0;
    tick();
    check("stall rd_cnt", rd_cnt, 32'(m_grants - g0));
`else
    g0 = m_grants;
    check("grant total", 32'(g0), 32'd14);
`endif

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tcdm_bank_responder.md
# tcdm_bank_responder

Single-bank TCDM memory model answering HWPE streamer load/store traffic on an array of `hwpe_stream_intf_tcdm` slave ports. It is the memory side of the accelerator's TCDM master ports: it arbitrates concurrent requests round-robin, serves one word access per cycle and returns read data with fixed one-cycle latency. It is used in the accelerator testbench and in standalone integrations that carry no cluster interconnect.

## Interface
- `NB_PORTS`, 3, number of TCDM slave ports (operand loads plus result store)
- `DATA_WIDTH`, 32, word width; fixed at 32 (byte enable is 4 bits)
- `MEM_WORDS`, 1024, bank depth in words; power of two
- `BASE_ADDR`, 32'h0, byte address mapped to word 0
- `STALL_SEED`, 16'hACE1, LFSR reset value, used only with the stall feature

Ports:
- `clk_i` in 1: single clock, all logic rising-edge
- `rst_i` in 1: reset, synchronous, active-high
- `clear_i` in 1: synchronous soft clear of counters, arbiter pointer and error flag
- `tcdm[NB_PORTS]` slave `hwpe_stream_intf_tcdm`: req, gnt, add[31:0], wen (1 = read), be[3:0], data[31:0], r_data[31:0], r_valid
- `rd_cnt_o` out 32: granted reads since reset/clear
- `wr_cnt_o` out 32: granted writes since reset/clear
- `err_o` out 1: sticky, set by any granted misaligned access

## Operation
- Reset values: all `gnt` = 0, all `r_valid` = 0, all `r_data` = 0, `rd_cnt_o` = 0, `wr_cnt_o` = 0, `err_o` = 0, arbiter pointer `rr_q` = 0. Memory contents are not reset.
- Arbitration: search ports `rr_q`, `rr_q+1`, … modulo NB_PORTS. The first port with `req` = 1 is granted. At most one `gnt` per cycle. After a grant to port k, `rr_q` ← (k+1) mod NB_PORTS. With no grant, `rr_q` holds.
- Address: word index = ((add − BASE_ADDR) >> 2) mod MEM_WORDS. Out-of-window addresses wrap silently.
- Misaligned access (add[1:0] ≠ 0): performed on the truncated word and sets `err_o`.
- Write (wen = 0): only the bytes with be[i] = 1 are updated. Increments `wr_cnt_o`.
- Read (wen = 1): the full word is returned and `be` is ignored. Increments `rd_cnt_o`.
- Response: the granted port receives `r_valid` = 1 in the next cycle. `r_data` carries the word for a read and 0 for a write. All other ports keep `r_valid` = 0 and `r_data` = 0.
- Counters wrap from 2^32−1 to 0.
- `clear_i`: zeroes the counters, `err_o` and `rr_q` at the next edge. A grant issued in the same cycle is still served, but its count is discarded.
- Reset while a response is pending: the response is dropped and `r_valid` is 0 in the cycle after reset.
- Read and write to the same word in the same cycle cannot occur (single grant). A read granted in the cycle after a write to the same word returns the written data.

## Timing
- `gnt` is combinational from `req` in the same cycle. A requester must hold req/add/wen/be/data stable until `gnt`.
- Read latency is exactly 1 cycle from grant to `r_valid`. Sustained throughput is 1 access per cycle across all ports.
- `r_data`, `r_valid`, the counters and `err_o` are registered.

## Configuration
- `TCDM_RESP_STALL_EN` defined:
  - A 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) is reset to STALL_SEED and advances every cycle; `clear_i` does not affect it.
  - All grants are suppressed in cycles where lfsr[1:0] = 2'b00, giving about 25% back-pressure.
- Not defined: no LFSR. A grant is issued in every cycle with at least one request.

## Structure
- Package `tcdm_resp_package` holds:
  - LFSR width, polynomial tap mask and default seed
  - typedef `tcdm_resp_t` {r_valid, r_data}
- Sub-module `tcdm_rr_arbiter` (NB_PORTS request vector in; one-hot grant and index out; pointer register inside, with clear and stall inputs).
- Memory array, counters and response register live in the top module.

## Test plan
- Port 0 writes 32'hDEADBEEF to add 0x10 with be = 4'hF, then port 1 reads 0x10 → port 1 `r_valid` 1 cycle after its gnt with r_data = 32'hDEADBEEF; rd_cnt_o = 1, wr_cnt_o = 1.
- Write 32'h11223344 to 0x20, then write 32'hAABBCCDD with be = 4'b0101, then read → r_data = 32'h11BB33DD.
- All 3 ports hold req for 6 cycles → grants in order 0, 1, 2, 0, 1, 2; each port gets `r_valid` one cycle after its own gnt.
- Read at BASE_ADDR + 4·MEM_WORDS + 1 → returns word 0 and err_o = 1 stays set; `clear_i` pulse → err_o = 0 and counters = 0.
- Assert `rst_i` in the cycle after a read grant → no `r_valid` follows; all outputs 0 next cycle.
- With `TCDM_RESP_STALL_EN`, 1000 back-to-back reads from one port → no grant in any cycle with lfsr[1:0] = 0; every granted read returns correct data; rd_cnt_o equals the number of grants.
